bus_gate_arbiter: RTL and testbench
===================================

# bus_gate_arbiter

Sequential arbiter that owns the four tri-state gate enables of the shared 16-bit LC-3 datapath bus (GateALU, GatePC, GateMARMUX, GateMDR). It takes one request line per bus driver, grants the bus to exactly one at a time with round-robin fairness, bounds how long any driver may hold the bus, and inserts dead cycles between owners so two drivers never overlap. It sits between the control unit and the bus mux; its gate outputs drive the mux select inputs directly.

## Interface
- MAX_HOLD, default 4: maximum consecutive granted cycles before forced release when another requester waits; 0 disables preemption; range 0..15.
- TURNAROUND, default 1: dead cycles (all gates low) between any release and the next grant; range 1..7.

- Clk  input  1  system clock, all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- req  input  4  bus requests; req[3]=ALU, req[2]=PC, req[1]=MARMUX, req[0]=MDR.
- GateALU  output  1  registered grant to ALU driver.
- GatePC  output  1  registered grant to PC driver.
- GateMARMUX  output  1  registered grant to MARMUX driver.
- GateMDR  output  1  registered grant to MDR driver.
- owner  output  2  index of current/last grantee (3=ALU … 0=MDR).
- bus_busy  output  1  high whenever any Gate output is high.
- preempt  output  1  one-cycle pulse on a MAX_HOLD forced release.

## Operation
- States: IDLE, GRANT, TURN.
- Gate outputs are one-hot in GRANT, all zero in IDLE and TURN. No other combination ever legal.
- Round-robin pointer ptr (2 bits) = index of last grantee. Search order starts at ptr-1 mod 4 and descends (3→2→1→0→3); first set req bit in that order wins. Reset value ptr=0, so first search starts at 3 (ALU).
- IDLE: if req≠0, winner latched, ptr←winner, owner←winner, hold_cnt←1, go GRANT. Else stay.
- GRANT: owner's Gate high.
  - req[owner]=0 → release, go TURN.
  - MAX_HOLD>0, hold_cnt==MAX_HOLD, and any other req bit set → release, preempt pulses, go TURN.
  - Otherwise stay; hold_cnt increments, saturating at MAX_HOLD.
- TURN: turn_cnt counts TURNAROUND cycles. In the last TURN cycle, arbitration runs as in IDLE: req≠0 → GRANT, else IDLE.
- Released owner competes normally after TURN but is last in rotation; a lone requester is re-granted.
- Requests appearing or dropping during TURN are evaluated only in its last cycle.
- owner holds last grantee value in IDLE/TURN.

## Timing
- Reset values: all Gate outputs 0, bus_busy 0, preempt 0, owner 0, ptr 0, hold_cnt 0, turn_cnt 0, state IDLE.
- Reset sampled high on any edge overrides all state, including mid-GRANT; Gate outputs low the cycle after.
- Grant latency from IDLE: req sampled at edge N → Gate high after edge N (visible cycle N+1).
- Release latency: req[owner] sampled low at edge N → Gate low after edge N.
- Dead time: exactly TURNAROUND cycles with all gates low between any two grants; next Gate high in the cycle after the last TURN cycle.
- Preempt: with MAX_HOLD=M, owner's Gate high exactly M cycles when contended; preempt high in the first TURN cycle only.
- Uncontended owner holds indefinitely; hold_cnt saturates, no preempt.
- All outputs registered; no combinational path from req to any output.

## Test plan
- Reset/idle: Reset=1 two cycles with req=4'b1111 → all Gates 0, owner 0, bus_busy 0; release Reset → GateALU high next cycle.
- Single request: req=4'b0100 held 3 cycles then 0 → GatePC high exactly 3 cycles, then TURNAROUND=1 dead cycle, state IDLE.
- Round-robin: req=4'b1111 held, MAX_HOLD=4, TURNAROUND=1 → grant order ALU, PC, MARMUX, MDR, ALU; each Gate 4 cycles, 1 dead cycle between, preempt pulse after each.
- No preemption when alone: req=4'b0001 held 20 cycles, MAX_HOLD=4 → GateMDR high continuously, preempt never asserted.
- Turnaround window: TURNAROUND=3, ALU releases while req[1] rises in first TURN cycle and drops in second → no grant, IDLE after TURN; req[1] held through TURN → GateMARMUX after 3 dead cycles.
- Reset mid-grant: GatePC high, Reset pulsed 1 cycle → all Gates low next cycle, ptr=0; with req=4'b0110 afterwards → GatePC granted first.

Source files
------------

// File: rtl/bus_gate_arbiter.sv
// Round-robin owner of the four LC-3 bus gate enables (ALU, PC, MARMUX, MDR).
// One driver is granted at a time. A contended owner is released after
// MAX_HOLD cycles. Every handover is separated by TURNAROUND dead cycles.
module bus_gate_arbiter #(
  parameter int MAX_HOLD   = 4,  // 0 disables forced release, 0..15
  parameter int TURNAROUND = 1   // dead cycles between owners, 1..7
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] req,        // [3]=ALU [2]=PC [1]=MARMUX [0]=MDR
  output logic       GateALU,
  output logic       GatePC,
  output logic       GateMARMUX,
  output logic       GateMDR,
  output logic [1:0] owner,
  output logic       bus_busy,
  output logic       preempt
);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  localparam logic [3:0] HOLD_LIM  = 4'(MAX_HOLD);
  // With preemption disabled the hold counter still saturates, just at its ceiling
  localparam logic [3:0] HOLD_SAT  = (MAX_HOLD == 0) ? 4'd15 : 4'(MAX_HOLD);
  localparam logic [2:0] TURN_LAST = 3'(TURNAROUND);

  state_t     state_reg;
  logic [1:0] ptr_reg;
  logic [1:0] owner_reg;
  logic [3:0] hold_cnt_reg;
  logic [2:0] turn_cnt_reg;
  logic [3:0] gate_reg;
  logic       bus_busy_reg;
  logic       preempt_reg;

  logic [1:0] win;
  logic [1:0] cand;
  logic       win_valid;
  logic [3:0] win_dec;
  logic [3:0] owner_dec;
  logic       others_req;

  // Winner search: start one below the last grantee and descend modulo 4, so
  // the last grantee itself is considered last.
  always_comb begin
    win       = ptr_reg;
    win_valid = 1'b0;
    cand      = 2'd0;
    for (int i = 4; i >= 1; i--) begin
      cand = ptr_reg - 2'(i);
      if (req[cand]) begin
        win       = cand;
        win_valid = 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dec
      assign win_dec[gi]   = (win == 2'(gi));
      assign owner_dec[gi] = (owner_reg == 2'(gi));
    end
  endgenerate

  assign others_req = |(req & ~owner_dec);

  // Arbitration FSM; every output is a register updated here
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg    <= IDLE;
      ptr_reg      <= 2'd0;
      owner_reg    <= 2'd0;
      hold_cnt_reg <= 4'd0;
      turn_cnt_reg <= 3'd0;
      gate_reg     <= 4'd0;
      bus_busy_reg <= 1'b0;
      preempt_reg  <= 1'b0;
    end else begin
      preempt_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (win_valid) begin
            state_reg    <= GRANT;
            ptr_reg      <= win;
            owner_reg    <= win;
            hold_cnt_reg <= 4'd1;
            gate_reg     <= win_dec;
            bus_busy_reg <= 1'b1;
          end
        end
        GRANT: begin
          if (!req[owner_reg]) begin
            state_reg    <= TURN;
            turn_cnt_reg <= 3'd1;
            gate_reg     <= 4'd0;
            bus_busy_reg <= 1'b0;
          end else if ((HOLD_LIM != 4'd0) && (hold_cnt_reg == HOLD_LIM) && others_req) begin
            state_reg    <= TURN;
            turn_cnt_reg <= 3'd1;
            gate_reg     <= 4'd0;
            bus_busy_reg <= 1'b0;
            preempt_reg  <= 1'b1;
          end else if (hold_cnt_reg < HOLD_SAT) begin
            hold_cnt_reg <= hold_cnt_reg + 4'd1;
          end
        end
        TURN: begin
          // Requests are only looked at in the final dead cycle
          if (turn_cnt_reg >= TURN_LAST) begin
            if (win_valid) begin
              state_reg    <= GRANT;
              ptr_reg      <= win;
              owner_reg    <= win;
              hold_cnt_reg <= 4'd1;
              gate_reg     <= win_dec;
              bus_busy_reg <= 1'b1;
            end else begin
              state_reg <= IDLE;
            end
          end else begin
            turn_cnt_reg <= turn_cnt_reg + 3'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign GateALU    = gate_reg[3];
  assign GatePC     = gate_reg[2];
  assign GateMARMUX = gate_reg[1];
  assign GateMDR    = gate_reg[0];
  assign owner      = owner_reg;
  assign bus_busy   = bus_busy_reg;
  assign preempt    = preempt_reg;

endmodule

// File: tb/tb_bus_gate_arbiter.sv
// Directed bench for bus_gate_arbiter: instance a uses MAX_HOLD=4/TURNAROUND=1,
// instance b uses MAX_HOLD=4/TURNAROUND=3. Each check packs
// {Gates[3:0], owner, bus_busy, preempt} into one byte.
module tb_bus_gate_arbiter;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       reset_a, reset_b;
  logic [3:0] req_a, req_b;
  logic       alu_a, pc_a, mar_a, mdr_a, busy_a, pre_a;
  logic       alu_b, pc_b, mar_b, mdr_b, busy_b, pre_b;
  logic [1:0] own_a, own_b;
  logic [7:0] obs_a, obs_b;

  int n_cmp  = 0;
  int n_fail = 0;

  bus_gate_arbiter #(.MAX_HOLD(4), .TURNAROUND(1)) dut_a (
    .Clk(Clk), .Reset(reset_a), .req(req_a),
    .GateALU(alu_a), .GatePC(pc_a), .GateMARMUX(mar_a), .GateMDR(mdr_a),
    .owner(own_a), .bus_busy(busy_a), .preempt(pre_a)
  );

  bus_gate_arbiter #(.MAX_HOLD(4), .TURNAROUND(3)) dut_b (
    .Clk(Clk), .Reset(reset_b), .req(req_b),
    .GateALU(alu_b), .GatePC(pc_b), .GateMARMUX(mar_b), .GateMDR(mdr_b),
    .owner(own_b), .bus_busy(busy_b), .preempt(pre_b)
  );

  assign obs_a = {alu_a, pc_a, mar_a, mdr_a, own_a, busy_a, pre_a};
  assign obs_b = {alu_b, pc_b, mar_b, mdr_b, own_b, busy_b, pre_b};

  function automatic logic [7:0] pk(input logic [3:0] g, input logic [1:0] o,
                                    input logic busy, input logic pre);
    return {g, o, busy, pre};
  endfunction

  // Advance one edge and settle away from it
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b required=%b", tag, obs, exp);
    end
    $display("t=%0t %-12s gates/own/busy/pre=%b expected=%b", $time, tag, obs, exp);
  endtask

  initial begin
    logic [1:0] o;

    // Reset held two cycles with every driver requesting
    reset_a = 1'b1; reset_b = 1'b1;
    req_a = 4'b1111; req_b = 4'b0000;
    tick(); chk("reset1", obs_a, pk(4'b0000, 2'd0, 1'b0, 1'b0));
    tick(); chk("reset2", obs_a, pk(4'b0000, 2'd0, 1'b0, 1'b0));
    reset_a = 1'b0; reset_b = 1'b0;

    // Round robin under full load: ALU first, each 4 cycles, one dead cycle w/ preempt
    for (int k = 0; k < 4; k++) begin
      o = 2'(3 - k);
      for (int c = 0; c < 4; c++) begin
        tick(); chk("rr_hold", obs_a, pk(4'b0001 << o, o, 1'b1, 1'b0));
      end
      tick(); chk("rr_preempt", obs_a, pk(4'b0000, o, 1'b0, 1'b1));
    end
    tick(); chk("rr_wrap", obs_a, pk(4'b1000, 2'd3, 1'b1, 1'b0));

    // Drop everything: release, one dead cycle, then idle
    req_a = 4'b0000;
    tick(); chk("rel_turn", obs_a, pk(4'b0000, 2'd3, 1'b0, 1'b0));
    tick(); chk("rel_idle", obs_a, pk(4'b0000, 2'd3, 1'b0, 1'b0));

    // Single PC request for 3 sampled edges
    req_a = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      tick(); chk("pc_hold", obs_a, pk(4'b0100, 2'd2, 1'b1, 1'b0));
    end
    req_a = 4'b0000;
    tick(); chk("pc_release", obs_a, pk(4'b0000, 2'd2, 1'b0, 1'b0));
    tick(); chk("pc_idle", obs_a, pk(4'b0000, 2'd2, 1'b0, 1'b0));
    tick(); chk("pc_idle2", obs_a, pk(4'b0000, 2'd2, 1'b0, 1'b0));

    // Lone MDR request is never preempted
    req_a = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      tick(); chk("mdr_alone", obs_a, pk(4'b0001, 2'd0, 1'b1, 1'b0));
    end
    // Contention after saturation forces release on the next edge
    req_a = 4'b1001;
    tick(); chk("mdr_preempt", obs_a, pk(4'b0000, 2'd0, 1'b0, 1'b1));
    tick(); chk("alu_after", obs_a, pk(4'b1000, 2'd3, 1'b1, 1'b0));

    // Hand over to PC, then reset in the middle of its grant
    req_a = 4'b0100;
    tick(); chk("alu_drop", obs_a, pk(4'b0000, 2'd3, 1'b0, 1'b0));
    tick(); chk("pc_grant", obs_a, pk(4'b0100, 2'd2, 1'b1, 1'b0));
    reset_a = 1'b1;
    tick(); chk("mid_reset", obs_a, pk(4'b0000, 2'd0, 1'b0, 1'b0));
    reset_a = 1'b0;
    req_a = 4'b0110;
    tick(); chk("post_reset", obs_a, pk(4'b0100, 2'd2, 1'b1, 1'b0));
    req_a = 4'b0000;

    // TURNAROUND=3: a request that comes and goes inside TURN is ignored
    req_b = 4'b1000;
    tick(); chk("b_alu", obs_b, pk(4'b1000, 2'd3, 1'b1, 1'b0));
    req_b = 4'b0000;
    tick(); chk("b_turn1", obs_b, pk(4'b0000, 2'd3, 1'b0, 1'b0));
    req_b = 4'b0010;
    tick(); chk("b_turn2", obs_b, pk(4'b0000, 2'd3, 1'b0, 1'b0));
    req_b = 4'b0000;
    tick(); chk("b_turn3", obs_b, pk(4'b0000, 2'd3, 1'b0, 1'b0));
    tick(); chk("b_idle", obs_b, pk(4'b0000, 2'd3, 1'b0, 1'b0));
    tick(); chk("b_idle2", obs_b, pk(4'b0000, 2'd3, 1'b0, 1'b0));

    // Request held through TURN is granted after exactly 3 dead cycles
    req_b = 4'b1000;
    tick(); chk("b_alu2", obs_b, pk(4'b1000, 2'd3, 1'b1, 1'b0));
    req_b = 4'b0010;
    tick(); chk("b_dead1", obs_b, pk(4'b0000, 2'd3, 1'b0, 1'b0));
    tick(); chk("b_dead2", obs_b, pk(4'b0000, 2'd3, 1'b0, 1'b0));
    tick(); chk("b_dead3", obs_b, pk(4'b0000, 2'd3, 1'b0, 1'b0));
    tick(); chk("b_marmux", obs_b, pk(4'b0010, 2'd1, 1'b1, 1'b0));
    req_b = 4'b0000;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
